// File: rtl/apb_master_mux.sv
// APB master turning a valid/ready request stream into APB transfers to NUM_SLAVES peripherals.
// The top address bits select the slave; decode misses and wait-state timeouts return an error response.
module apb_master_mux #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_write_i,
    input  logic [ADDR_W-1:0]            req_addr_i,
    input  logic [DATA_W-1:0]            req_wdata_i,
    output logic                         rsp_valid_o,
    output logic [DATA_W-1:0]            rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic [NUM_SLAVES-1:0]        psel_o,
    output logic                         penable_o,
    output logic [ADDR_W-1:0]            paddr_o,
    output logic                         pwrite_o,
    output logic [DATA_W-1:0]            pwdata_o,
    input  logic [NUM_SLAVES-1:0]        pready_i,
    input  logic [NUM_SLAVES-1:0]        pslverr_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata_i
);
    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state;
    logic [SEL_W-1:0]      idx;
    logic [TO_W-1:0]       tcnt;
    logic                  miss_pend;

    logic [SEL_W-1:0]      req_idx;
    logic                  req_hit;
    logic [NUM_SLAVES-1:0] req_onehot;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  in_access;
    logic                  done;
    logic                  timeout_hit;
    logic                  accept;

    always_comb begin
        req_idx    = req_addr_i[ADDR_W-1 -: SEL_W];
        req_hit    = (32'(req_idx) < NUM_SLAVES);
        req_onehot = '0;
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (req_idx == SEL_W'(k)) req_onehot[k] = 1'b1;
            if (idx == SEL_W'(k)) begin
                sel_ready = pready_i[k];
                sel_err   = pslverr_i[k];
                sel_rdata = prdata_i[k*DATA_W +: DATA_W];
            end
        end
        in_access   = (state == ACCESS);
        done        = in_access && sel_ready;
        timeout_hit = (TIMEOUT != 0) && in_access && !sel_ready && (tcnt == TO_LAST);
        req_ready_o = ((state == IDLE) && !miss_pend) || done;
        accept      = req_valid_i && req_ready_o;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            tcnt        <= '0;
            miss_pend   <= 1'b0;
            psel_o      <= '0;
            penable_o   <= 1'b0;
            paddr_o     <= '0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;

            // A miss accepted on a completion cycle is answered one cycle after the completion response.
            if (miss_pend) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= 1'b1;
                miss_pend   <= 1'b0;
            end

            case (state)
                IDLE: ;
                SETUP: begin
                    state     <= ACCESS;
                    penable_o <= 1'b1;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= sel_err;
                        rsp_rdata_o <= pwrite_o ? '0 : sel_rdata;
                        psel_o      <= '0;
                        penable_o   <= 1'b0;
                        state       <= IDLE;
                    end else if (timeout_hit) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        psel_o      <= '0;
                        penable_o   <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                if (req_hit) begin
                    state     <= SETUP;
                    idx       <= req_idx;
                    tcnt      <= '0;
                    psel_o    <= req_onehot;
                    penable_o <= 1'b0;
                    paddr_o   <= req_addr_i;
                    pwrite_o  <= req_write_i;
                    pwdata_o  <= req_wdata_i;
                end else if (state == IDLE) begin
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b1;
                end else begin
                    miss_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_mux.sv
// Bench for apb_master_mux: directed scenarios on a 4-slave instance, miss/reset and
// randomized traffic against a request-level reference model on a 3-slave instance.
module tb_apb_master_mux;
    localparam int unsigned TO3 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic         reset4, v4, rdy4, wr4, rv4, re4, pen4, pwrite4;
    logic [31:0]  addr4, wdata4, rd4, paddr4, pwdata4;
    logic [3:0]   psel4, pready4, pslverr4;
    logic [127:0] prdata4;

    logic         reset3, v3, rdy3, wr3, rv3, re3, pen3, pwrite3;
    logic [31:0]  addr3, wdata3, rd3, paddr3, pwdata3;
    logic [2:0]   psel3, pready3, pslverr3;
    logic [95:0]  prdata3;

    int unsigned  waits4, acc4, acc3;
    logic         serr4, hit4, hit3;
    logic [31:0]  rdval4;

    apb_master_mux #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT(16)) u_dut4 (
        .clk(clk), .reset(reset4), .req_valid_i(v4), .req_ready_o(rdy4), .req_write_i(wr4),
        .req_addr_i(addr4), .req_wdata_i(wdata4), .rsp_valid_o(rv4), .rsp_rdata_o(rd4),
        .rsp_err_o(re4), .psel_o(psel4), .penable_o(pen4), .paddr_o(paddr4), .pwrite_o(pwrite4),
        .pwdata_o(pwdata4), .pready_i(pready4), .pslverr_i(pslverr4), .prdata_i(prdata4));

    apb_master_mux #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .TIMEOUT(TO3)) u_dut3 (
        .clk(clk), .reset(reset3), .req_valid_i(v3), .req_ready_o(rdy3), .req_write_i(wr3),
        .req_addr_i(addr3), .req_wdata_i(wdata3), .rsp_valid_o(rv3), .rsp_rdata_o(rd3),
        .rsp_err_o(re3), .psel_o(psel3), .penable_o(pen3), .paddr_o(paddr3), .pwrite_o(pwrite3),
        .pwdata_o(pwdata3), .pready_i(pready3), .pslverr_i(pslverr3), .prdata_i(prdata3));

    // Slave behaviour of the 3-slave instance is a pure function of the transfer address.
    function automatic int unsigned wait_of(input logic [31:0] a);
        return 32'(a[3:2]) + ((a[4] & a[6]) ? 3 : 0);
    endfunction

    function automatic logic [31:0] hash3(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    // Slaves: the selected one follows its knobs, unselected ones drive noise.
    always @(negedge clk) begin
        if (pen4 && psel4 != 4'b0) begin hit4 = (acc4 == waits4); acc4 = acc4 + 1; end
        else begin hit4 = 1'b0; acc4 = 0; end
        pready4  = (4'($urandom) & ~psel4) | (hit4 ? psel4 : 4'b0);
        pslverr4 = (4'($urandom) & ~psel4) | (serr4 ? psel4 : 4'b0);
        for (int k = 0; k < 4; k++) prdata4[k*32 +: 32] = psel4[k] ? rdval4 : $urandom;

        if (pen3 && psel3 != 3'b0) begin hit3 = (acc3 == wait_of(paddr3)); acc3 = acc3 + 1; end
        else begin hit3 = 1'b0; acc3 = 0; end
        pready3  = (3'($urandom) & ~psel3) | (hit3 ? psel3 : 3'b0);
        pslverr3 = (3'($urandom) & ~psel3) | (paddr3[5] ? psel3 : 3'b0);
        for (int k = 0; k < 3; k++) prdata3[k*32 +: 32] = psel3[k] ? hash3(paddr3) : $urandom;
    end

    task automatic issue4(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e, output logic [31:0] r);
        lat = -1; e = 1'bx; r = 'x;
        @(posedge clk); #1;
        v4 = 1'b1; wr4 = wr; addr4 = a; wdata4 = d;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) v4 = 1'b0;
            if (lat < 0 && rv4 === 1'b1) begin lat = c; e = re4; r = rd4; end
        end
    endtask

    task automatic test_reset();
        reset4 = 1'b1; reset3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (psel4 !== 4'b0 || pen4 !== 1'b0 || psel3 !== 3'b0 || pen3 !== 1'b0) begin errors++;
            $display("FAIL reset_apb_ctrl: got psel4=%b pen4=%b psel3=%b pen3=%b want all 0", psel4, pen4, psel3, pen3); end
        checks++; if (rv4 !== 1'b0 || re4 !== 1'b0 || rd4 !== 32'h0) begin errors++;
            $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h want 0 0 0", rv4, re4, rd4); end
        checks++; if (paddr4 !== 32'h0 || pwdata4 !== 32'h0 || pwrite4 !== 1'b0) begin errors++;
            $display("FAIL reset_apb_data: got paddr=%h pwdata=%h pwrite=%b want 0", paddr4, pwdata4, pwrite4); end
        checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy4); end
        reset4 = 1'b0; reset3 = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        waits4 = 0; serr4 = 1'b0; rdval4 = 32'h1111_2222;
        @(posedge clk); #1;
        v4 = 1'b1; wr4 = 1'b1; addr4 = 32'h4000_0010; wdata4 = 32'hDEAD_CAFE;
        checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL t1_ready_idle: got %b want 1", rdy4); end
        @(posedge clk); #1; v4 = 1'b0;
        checks++; if (psel4 !== 4'b0010 || pen4 !== 1'b0) begin errors++;
            $display("FAIL t1_setup: got psel=%b pen=%b want 0010 0", psel4, pen4); end
        checks++; if (paddr4 !== 32'h4000_0010 || pwdata4 !== 32'hDEAD_CAFE || pwrite4 !== 1'b1) begin errors++;
            $display("FAIL t1_fields: got %h %h %b want 40000010 deadcafe 1", paddr4, pwdata4, pwrite4); end
        @(posedge clk); #1;
        checks++; if (psel4 !== 4'b0010 || pen4 !== 1'b1) begin errors++;
            $display("FAIL t1_access: got psel=%b pen=%b want 0010 1", psel4, pen4); end
        @(posedge clk); #1;
        checks++; if (rv4 !== 1'b1 || re4 !== 1'b0 || rd4 !== 32'h0) begin errors++;
            $display("FAIL t1_rsp: got valid=%b err=%b rdata=%h want 1 0 0", rv4, re4, rd4); end
        checks++; if (psel4 !== 4'b0 || pen4 !== 1'b0) begin errors++;
            $display("FAIL t1_release: got psel=%b pen=%b want 0 0", psel4, pen4); end
        @(posedge clk); #1;
        checks++; if (rv4 !== 1'b0) begin errors++; $display("FAIL t1_pulse_width: got %b want 0", rv4); end
        checks++; if (paddr4 !== 32'h4000_0010 || pwrite4 !== 1'b1) begin errors++;
            $display("FAIL t1_idle_hold: got paddr=%h pwrite=%b want 40000010 1", paddr4, pwrite4); end
    endtask

    task automatic test_read_waits();
        waits4 = 3; serr4 = 1'b0; rdval4 = 32'h1234_5678;
        @(posedge clk); #1;
        v4 = 1'b1; wr4 = 1'b0; addr4 = 32'h8000_0004; wdata4 = $urandom;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin v4 = 1'b0; wr4 = 1'b1; addr4 = 32'hFFFF_FFFF; end
            checks++; if (paddr4 !== 32'h8000_0004 || pwrite4 !== 1'b0 || psel4 !== 4'b0100 || pen4 !== (c >= 2)) begin
                errors++; $display("FAIL t2_stable_c%0d: got paddr=%h pwrite=%b psel=%b pen=%b", c, paddr4, pwrite4, psel4, pen4); end
            @(negedge clk); #1;
            checks++; if (rdy4 !== (c == 5)) begin errors++;
                $display("FAIL t2_ready_c%0d: got %b want %b", c, rdy4, (c == 5)); end
        end
        @(posedge clk); #1;
        checks++; if (rv4 !== 1'b1 || re4 !== 1'b0 || rd4 !== 32'h1234_5678) begin errors++;
            $display("FAIL t2_rsp: got valid=%b err=%b rdata=%h want 1 0 12345678", rv4, re4, rd4); end
    endtask

    task automatic test_back_to_back();
        waits4 = 0; serr4 = 1'b0; rdval4 = 32'hA5A5_0001;
        @(posedge clk); #1;
        v4 = 1'b1; wr4 = 1'b1; addr4 = 32'h0000_0100; wdata4 = 32'h0BAD_F00D;
        @(posedge clk); #1;
        wr4 = 1'b0; addr4 = 32'hC000_0200;
        checks++; if (psel4 !== 4'b0001 || pen4 !== 1'b0) begin errors++;
            $display("FAIL t3_setup_a: got psel=%b pen=%b want 0001 0", psel4, pen4); end
        @(posedge clk); #1;
        checks++; if (psel4 !== 4'b0001 || pen4 !== 1'b1) begin errors++;
            $display("FAIL t3_access_a: got psel=%b pen=%b want 0001 1", psel4, pen4); end
        @(posedge clk); #1; v4 = 1'b0;
        checks++; if (psel4 !== 4'b1000 || pen4 !== 1'b0 || paddr4 !== 32'hC000_0200 || pwrite4 !== 1'b0) begin errors++;
            $display("FAIL t3_setup_b: got psel=%b pen=%b paddr=%h pwrite=%b", psel4, pen4, paddr4, pwrite4); end
        checks++; if (rv4 !== 1'b1 || re4 !== 1'b0 || rd4 !== 32'h0) begin errors++;
            $display("FAIL t3_rsp_a: got valid=%b err=%b rdata=%h want 1 0 0", rv4, re4, rd4); end
        @(posedge clk); #1;
        checks++; if (rv4 !== 1'b0 || psel4 !== 4'b1000 || pen4 !== 1'b1) begin errors++;
            $display("FAIL t3_access_b: got valid=%b psel=%b pen=%b want 0 1000 1", rv4, psel4, pen4); end
        @(posedge clk); #1;
        checks++; if (rv4 !== 1'b1 || re4 !== 1'b0 || rd4 !== 32'hA5A5_0001) begin errors++;
            $display("FAIL t3_rsp_b: got valid=%b err=%b rdata=%h want 1 0 a5a50001", rv4, re4, rd4); end
    endtask

    task automatic test_slverr();
        int lat; logic e; logic [31:0] r;
        waits4 = 1; serr4 = 1'b1; rdval4 = 32'h7777_8888;
        issue4(1'b1, 32'hC000_0008, 32'h1357_9BDF, lat, e, r);
        checks++; if (lat !== 4 || e !== 1'b1 || r !== 32'h0) begin errors++;
            $display("FAIL t4_write_err: got lat=%0d err=%b rdata=%h want 4 1 0", lat, e, r); end
        waits4 = 0; serr4 = 1'b1; rdval4 = 32'h0000_CAFE;
        issue4(1'b0, 32'h4000_0000, 32'h0, lat, e, r);
        checks++; if (lat !== 3 || e !== 1'b1 || r !== 32'h0000_CAFE) begin errors++;
            $display("FAIL t4_read_err: got lat=%0d err=%b rdata=%h want 3 1 0000cafe", lat, e, r); end
        serr4 = 1'b0; rdval4 = 32'h2468_ACE0;
        issue4(1'b0, 32'h0000_0040, 32'h0, lat, e, r);
        checks++; if (lat !== 3 || e !== 1'b0 || r !== 32'h2468_ACE0) begin errors++;
            $display("FAIL t4_next_ok: got lat=%0d err=%b rdata=%h want 3 0 2468ace0", lat, e, r); end
    endtask

    task automatic test_timeout();
        int pen_cnt, lat; logic e; logic [31:0] r; logic [3:0] ps;
        waits4 = 1000; serr4 = 1'b0; rdval4 = 32'h5555_AAAA;
        pen_cnt = 0; lat = -1; e = 1'bx; r = 'x; ps = 'x;
        @(posedge clk); #1;
        v4 = 1'b1; wr4 = 1'b0; addr4 = 32'h8000_0020;
        @(posedge clk); #1; v4 = 1'b0;
        for (int c = 2; c <= 40; c++) begin
            @(posedge clk); #1;
            if (lat < 0 && pen4 === 1'b1) pen_cnt++;
            if (lat < 0 && rv4 === 1'b1) begin lat = c; e = re4; r = rd4; ps = psel4; end
        end
        checks++; if (pen_cnt !== 16) begin errors++; $display("FAIL t5_penable_cycles: got %0d want 16", pen_cnt); end
        checks++; if (lat !== 18 || e !== 1'b1 || r !== 32'h0 || ps !== 4'b0) begin errors++;
            $display("FAIL t5_abort_rsp: got lat=%0d err=%b rdata=%h psel=%b want 18 1 0 0", lat, e, r, ps); end
        waits4 = 2; rdval4 = 32'h0F0F_1234;
        issue4(1'b0, 32'h8000_0024, 32'h0, lat, e, r);
        checks++; if (lat !== 5 || e !== 1'b0 || r !== 32'h0F0F_1234) begin errors++;
            $display("FAIL t5_recover: got lat=%0d err=%b rdata=%h want 5 0 0f0f1234", lat, e, r); end
    endtask

    task automatic test_miss_and_reset();
        logic seen;
        @(posedge clk); #1;
        v3 = 1'b1; wr3 = 1'b0; addr3 = 32'hC000_0000;
        checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL t6_miss_ready: got %b want 1", rdy3); end
        @(posedge clk); #1; v3 = 1'b0;
        checks++; if (psel3 !== 3'b0 || pen3 !== 1'b0) begin errors++;
            $display("FAIL t6_miss_nosel: got psel=%b pen=%b want 000 0", psel3, pen3); end
        checks++; if (rv3 !== 1'b1 || re3 !== 1'b1 || rd3 !== 32'h0) begin errors++;
            $display("FAIL t6_miss_rsp: got valid=%b err=%b rdata=%h want 1 1 0", rv3, re3, rd3); end
        @(posedge clk); #1;
        checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL t6_miss_pulse: got %b want 0", rv3); end
        v3 = 1'b1; wr3 = 1'b1; addr3 = 32'h4000_005C; wdata3 = 32'h9999_0000;
        @(posedge clk); #1; v3 = 1'b0;
        @(posedge clk); #1;
        checks++; if (psel3 !== 3'b010 || pen3 !== 1'b1) begin errors++;
            $display("FAIL t6_in_access: got psel=%b pen=%b want 010 1", psel3, pen3); end
        #2 reset3 = 1'b1;
        #1;
        checks++; if (psel3 !== 3'b0 || pen3 !== 1'b0 || paddr3 !== 32'h0) begin errors++;
            $display("FAIL t6_reset_drop: got psel=%b pen=%b paddr=%h want 0", psel3, pen3, paddr3); end
        @(posedge clk); #1; reset3 = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (rv3 !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t6_no_rsp_after_reset: got rsp_valid seen=%b want 0", seen); end
    endtask

    task automatic test_random_traffic();
        logic        q_err[$];
        logic [31:0] q_dat[$];
        bit          drv_done;
        int          sent;
        drv_done = 1'b0; sent = 0;
        fork
            begin
                bit took;
                int guard;
                took = 1'b1; guard = 0;
                while (sent < 80 && guard < 3000) begin
                    guard++;
                    @(posedge clk); #1;
                    if (took || !v3) begin
                        took = 1'b0;
                        if ($urandom_range(3) != 0) begin
                            v3 = 1'b1; wr3 = 1'($urandom); addr3 = $urandom; wdata3 = $urandom;
                        end else v3 = 1'b0;
                    end
                    @(negedge clk); #1;
                    if (v3 && rdy3) begin
                        took = 1'b1; sent++;
                        if (addr3[31:30] == 2'b11 || wait_of(addr3) >= TO3) begin
                            q_err.push_back(1'b1); q_dat.push_back(32'h0);
                        end else begin
                            q_err.push_back(addr3[5]); q_dat.push_back(wr3 ? 32'h0 : hash3(addr3));
                        end
                    end
                end
                @(posedge clk); #1; v3 = 1'b0;
                drv_done = 1'b1;
            end
            begin
                int c;
                logic        ee;
                logic [31:0] ed;
                c = 0;
                while (!(drv_done && q_err.size() == 0) && c < 5000) begin
                    c++;
                    @(negedge clk);
                    checks++; if ($countones(psel3) > 1 || (pen3 && psel3 == 3'b0)) begin errors++;
                        $display("FAIL rnd_psel_shape: got psel=%b pen=%b", psel3, pen3); end
                    if (rv3 === 1'b1) begin
                        checks++;
                        if (q_err.size() == 0) begin errors++;
                            $display("FAIL rnd_unexpected_rsp: got err=%b rdata=%h want no response", re3, rd3);
                        end else begin
                            ee = q_err.pop_front(); ed = q_dat.pop_front();
                            if (re3 !== ee || rd3 !== ed) begin errors++;
                                $display("FAIL rnd_rsp: got err=%b rdata=%h want err=%b rdata=%h", re3, rd3, ee, ed); end
                        end
                    end
                end
                checks++; if (c >= 5000) begin errors++;
                    $display("FAIL rnd_drain_timeout: got %0d responses outstanding want 0", q_err.size()); end
            end
        join
        checks++; if (sent !== 80) begin errors++; $display("FAIL rnd_accepts: got %0d want 80", sent); end
    endtask

    initial begin
        v4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
        v3 = 1'b0; wr3 = 1'b0; addr3 = '0; wdata3 = '0;
        waits4 = 0; serr4 = 1'b0; rdval4 = '0; acc4 = 0; acc3 = 0; hit4 = 1'b0; hit3 = 1'b0;
        pready4 = '0; pslverr4 = '0; prdata4 = '0;
        pready3 = '0; pslverr3 = '0; prdata3 = '0;
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_back_to_back();
        test_slverr();
        test_timeout();
        test_miss_and_reset();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
